// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, bit timing, LSB-first
// deserialization, optional parity and stop checks, one-cycle valid strobe.
module uart_rx_ctrl #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PRE_MIN = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              RX_IN,
    input  logic [5:0]        prescale,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              sampled_bit,
    output logic              samp_en,
    output logic [5:0]        samp_prescale,
    output logic [5:0]        edge_count,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stop_err
);

    localparam int unsigned PRE_W = 6;
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state, state_nxt;
    logic [PRE_W-1:0]    edge_nxt, pre_nxt;
    logic [DATA_W-1:0]   shreg, shreg_nxt, pdata_nxt;
    logic [CNT_W-1:0]    bit_cnt, cnt_nxt;
    logic                par_typ_q, par_typ_nxt;
    logic                valid_nxt, par_err_nxt, stop_err_nxt, samp_en_nxt;
    logic                bit_end_c;

    // Next-state and datapath decisions; everything is decided on bit_end.
    always_comb begin
        state_nxt    = state;
        edge_nxt     = edge_count;
        pre_nxt      = samp_prescale;
        shreg_nxt    = shreg;
        cnt_nxt      = bit_cnt;
        par_typ_nxt  = par_typ_q;
        pdata_nxt    = P_DATA;
        valid_nxt    = 1'b0;
        par_err_nxt  = par_err;
        stop_err_nxt = stop_err;

        bit_end_c = (state != IDLE) && (edge_count == samp_prescale - PRE_W'(1));

        if (state != IDLE) begin
            edge_nxt = bit_end_c ? '0 : edge_count + PRE_W'(1);
        end

        unique case (state)
            IDLE: begin
                if (!RX_IN) begin
                    pre_nxt      = (prescale < PRE_W'(PRE_MIN)) ? PRE_W'(PRE_MIN) : prescale;
                    par_err_nxt  = 1'b0;
                    stop_err_nxt = 1'b0;
                    cnt_nxt      = '0;
                    edge_nxt     = '0;
                    state_nxt    = START;
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_nxt = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    shreg_nxt = {sampled_bit, shreg[DATA_W-1:1]};
                    cnt_nxt   = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        par_typ_nxt = PAR_TYP;
                        state_nxt   = PAR_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end_c) begin
                    par_err_nxt = (sampled_bit != (^shreg ^ par_typ_q));
                    state_nxt   = STOP;
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    stop_err_nxt = !sampled_bit;
                    if (!par_err && sampled_bit) begin
                        pdata_nxt = shreg;
                        valid_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        samp_en_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            samp_en       <= 1'b0;
            edge_count    <= '0;
            samp_prescale <= PRE_W'(PRE_MIN);
            shreg         <= '0;
            bit_cnt       <= '0;
            par_typ_q     <= 1'b0;
            P_DATA        <= '0;
            data_valid    <= 1'b0;
            par_err       <= 1'b0;
            stop_err      <= 1'b0;
        end else begin
            state         <= state_nxt;
            samp_en       <= samp_en_nxt;
            edge_count    <= edge_nxt;
            samp_prescale <= pre_nxt;
            shreg         <= shreg_nxt;
            bit_cnt       <= cnt_nxt;
            par_typ_q     <= par_typ_nxt;
            P_DATA        <= pdata_nxt;
            data_valid    <= valid_nxt;
            par_err       <= par_err_nxt;
            stop_err      <= stop_err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: drives serial frames with a simple
// mid-bit sampler model and checks received bytes through a scoreboard.
module tb_uart_rx_ctrl;

    logic       clk;
    logic       rstn;
    logic       RX_IN;
    logic [5:0] prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic       samp_en;
    logic [5:0] samp_prescale;
    logic [5:0] edge_count;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stop_err;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc_n = 0;
    int         valid_cnt = 0;
    int         n_good = 0;
    int         t0 = 0;
    int         t0a = 0;
    logic [7:0] last_good = 8'h00;
    logic [7:0] sb[$];
    int         vq[$];

    uart_rx_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .RX_IN        (RX_IN),
        .prescale     (prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .sampled_bit  (sampled_bit),
        .samp_en      (samp_en),
        .samp_prescale(samp_prescale),
        .edge_count   (edge_count),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stop_err     (stop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; every valid strobe is matched against the scoreboard.
    task automatic cyc();
        logic [7:0] exp_b;
        @(posedge clk);
        #1;
        cyc_n++;
        if (data_valid === 1'b1) begin
            valid_cnt++;
            vq.push_back(cyc_n);
            check("valid_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_b = sb.pop_front();
                check("p_data", 32'(P_DATA), 32'(exp_b));
                last_good = exp_b;
            end
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        for (int i = 0; i < n; i++) cyc();
    endtask

    // One line bit of p cycles; the sampler model latches the line mid-bit.
    task automatic send_bit(input logic v, input int p);
        for (int i = 0; i < p; i++) begin
            RX_IN = v;
            if (i == p / 2) sampled_bit = v;
            cyc();
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic pbit, input logic sbit,
                              input logic [5:0] pin, input int p, input logic chg);
        prescale = pin;
        PAR_EN   = pe;
        PAR_TYP  = pt;
        if (sbit && (!pe || (pbit == (^d ^ pt)))) begin
            sb.push_back(d);
            n_good++;
        end
        t0 = cyc_n;
        send_bit(1'b0, p);
        for (int i = 0; i < 8; i++) begin
            if (chg && i == 4) prescale = 6'd8;
            send_bit(d[i], p);
        end
        if (pe) send_bit(pbit, p);
        if (chg) begin
            check("samp_prescale_held", 32'(samp_prescale), 32'(p));
            prescale = pin;
        end
        send_bit(sbit, p);
        RX_IN = 1'b1;
    endtask

    // Called in the last cycle of the stop bit of a good frame.
    task automatic expect_valid();
        check("valid_not_early", 32'(data_valid), 32'd0);
        cyc();
        check("valid_strobe", 32'(data_valid), 32'd1);
        cyc();
        check("valid_one_cycle", 32'(data_valid), 32'd0);
    endtask

    task automatic check_reset();
        check("rst_samp_en", 32'(samp_en), 32'd0);
        check("rst_edge_count", 32'(edge_count), 32'd0);
        check("rst_p_data", 32'(P_DATA), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_par_err", 32'(par_err), 32'd0);
        check("rst_stop_err", 32'(stop_err), 32'd0);
        check("rst_samp_prescale", 32'(samp_prescale), 32'd8);
    endtask

    initial begin
        rstn = 1'b1; RX_IN = 1'b1; sampled_bit = 1'b1;
        prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        #2 rstn = 1'b0;
        cyc(); cyc();
        check_reset();
        rstn = 1'b1;
        idle(3);

        // P=8, no parity, 0xA5: valid in cycle 81
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8, 8, 1'b0);
        expect_valid();
        check("t1_par_err", 32'(par_err), 32'd0);
        check("t1_stop_err", 32'(stop_err), 32'd0);
        idle(4);

        // P=16, even parity, 0x3C good then bad parity bit
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 6'd16, 16, 1'b0);
        expect_valid();
        idle(4);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 6'd16, 16, 1'b0);
        idle(4);
        check("t2_par_err", 32'(par_err), 32'd1);
        check("t2_stop_err", 32'(stop_err), 32'd0);
        check("t2_p_data_kept", 32'(P_DATA), 32'(last_good));

        // Odd parity ok, stop bit low; prescale 5 is clamped to 8
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 6'd5, 8, 1'b0);
        idle(4);
        check("t3_par_err", 32'(par_err), 32'd0);
        check("t3_stop_err", 32'(stop_err), 32'd1);
        check("t3_clamp", 32'(samp_prescale), 32'd8);
        check("t3_p_data_kept", 32'(P_DATA), 32'(last_good));

        // Glitch: line low for 2 cycles
        RX_IN = 1'b0;
        cyc();
        check("t4_samp_en_on", 32'(samp_en), 32'd1);
        check("t4_edge_start", 32'(edge_count), 32'd0);
        check("t4_stop_err_clr", 32'(stop_err), 32'd0);
        sampled_bit = 1'b1;
        cyc();
        RX_IN = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        check("t4_edge_last", 32'(edge_count), 32'd7);
        check("t4_samp_en_last", 32'(samp_en), 32'd1);
        cyc();
        check("t4_samp_en_off", 32'(samp_en), 32'd0);
        check("t4_edge_idle", 32'(edge_count), 32'd0);
        idle(3);
        check("t4_par_err", 32'(par_err), 32'd0);
        check("t4_stop_err", 32'(stop_err), 32'd0);

        // Back-to-back at P=32 with even parity; prescale pokes mid-frame
        vq.delete();
        t0a = cyc_n;
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 6'd32, 32, 1'b1);
        send_frame(8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 6'd32, 32, 1'b0);
        idle(4);
        check("t5_strobes", 32'(vq.size()), 32'd2);
        if (vq.size() == 2) begin
            check("t5_first_valid_cycle", 32'(vq[0] - t0a), 32'd353);
            check("t5_spacing_ok", 32'((vq[1] - vq[0] >= 352) && (vq[1] - vq[0] <= 353)), 32'd1);
        end

        // Asynchronous reset in the middle of DATA
        PAR_EN = 1'b0; prescale = 6'd8;
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        check("t6_busy", 32'(samp_en), 32'd1);
        rstn = 1'b0;
        #1;
        check_reset();
        RX_IN = 1'b1; sampled_bit = 1'b1;
        cyc(); cyc();
        rstn = 1'b1;
        idle(3);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8, 8, 1'b0);
        expect_valid();
        idle(3);

        check("valid_count", 32'(valid_cnt), 32'(n_good));
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
